aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_if.sv | 39 +++
 rtl/aes_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - control/handshake bundle between a block sequencer client and aes_round_ctrl
//
// Signals:
//   start, abort        one-cycle block request / cancel from the control register
//   ld                  load key + plaintext, apply round-0 AddRoundKey
//   rnd_en, rnd_final   advance one round; final round (no MixColumns)
//   rnd_idx, rcon       round being executed and its key-expansion constant
//   busy                block in progress
//   out_valid/out_ready result handshake
//   overrun, ovr_clr    sticky "start while occupied" flag and its clear
//
// Modports:
//   master  the client that issues requests and consumes the result
//   slave   the round controller itself

interface aes_round_ctrl_if;
  logic       start;
  logic       abort;
  logic       ld;
  logic       rnd_en;
  logic       rnd_final;
  logic [3:0] rnd_idx;
  logic [7:0] rcon;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       ovr_clr;

  modport master (
    output start, abort, out_ready, ovr_clr,
    input  ld, rnd_en, rnd_final, rnd_idx, rcon, busy, out_valid, overrun
  );

  modport slave (
    input  start, abort, out_ready, ovr_clr,
    output ld, rnd_en, rnd_final, rnd_idx, rcon, busy, out_valid, overrun
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencer: load, NR rounds, result handshake, overrun flag
//
// Parameters:
//   NR      number of AES rounds; 10, 12 or 14 (AES-128/192/256)
//
// Ports:
//   ACLK    clock, all state changes on the rising edge
//   ARESET  asynchronous active-high reset; assertion takes effect at once,
//           release is synchronised to ACLK internally
//   ctrl    aes_round_ctrl_if.slave: start/abort/ovr_clr/out_ready in,
//           ld/rnd_en/rnd_final/rnd_idx/rcon/busy/out_valid/overrun out
//
// Sequence per block: IDLE -start-> LOAD (1 cycle, ld) -> ROUND (rnd_idx
// 1..NR-1) -> FINAL (rnd_idx NR, rnd_final) -> DONE (out_valid until
// out_ready) -> IDLE. All outputs are registers updated together with the
// state, so they never glitch combinationally.

module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic             ACLK,
  input  logic             ARESET,
  aes_round_ctrl_if.slave  ctrl
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_ROUND_IDX = 4'(NR - 1);
  localparam logic [3:0] FINAL_IDX      = 4'(NR);

  // Reset bridge: ARESET asserts rst_sync immediately, but its release is
  // delayed through two flops so the FSM never sees a reset edge close to
  // a clock edge.
  logic rst_meta;
  logic rst_sync;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // Key-schedule round constant step: multiply by x in GF(2^8).
  function automatic logic [7:0] rcon_next(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  state_t     state;
  logic       ld_q;
  logic       rnd_en_q;
  logic       rnd_final_q;
  logic [3:0] rnd_idx_q;
  logic [7:0] rcon_q;
  logic       busy_q;
  logic       out_valid_q;
  logic       overrun_q;

  always_ff @(posedge ACLK or posedge rst_sync) begin
    if (rst_sync) begin
      state       <= S_IDLE;
      ld_q        <= 1'b0;
      rnd_en_q    <= 1'b0;
      rnd_final_q <= 1'b0;
      rnd_idx_q   <= 4'd0;
      rcon_q      <= 8'h00;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // A start that cannot be accepted is recorded; a simultaneous clear
      // loses so the event is never silently dropped.
      if (ctrl.start && (state != S_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (ctrl.ovr_clr) begin
        overrun_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          // abort is meaningless here, so start always wins.
          if (ctrl.start) begin
            state     <= S_LOAD;
            ld_q      <= 1'b1;
            busy_q    <= 1'b1;
            rnd_idx_q <= 4'd0;
          end
        end

        S_LOAD: begin
          if (ctrl.abort) begin
            state     <= S_IDLE;
            ld_q      <= 1'b0;
            busy_q    <= 1'b0;
            rnd_idx_q <= 4'd0;
          end else begin
            // rcon for round 1 is loaded here so it is on the port for the
            // first rnd_en cycle.
            state     <= S_ROUND;
            ld_q      <= 1'b0;
            rnd_en_q  <= 1'b1;
            rnd_idx_q <= 4'd1;
            rcon_q    <= 8'h01;
          end
        end

        S_ROUND: begin
          if (ctrl.abort) begin
            state     <= S_IDLE;
            rnd_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            rnd_idx_q <= 4'd0;
          end else begin
            rcon_q <= rcon_next(rcon_q);
            if (rnd_idx_q == LAST_ROUND_IDX) begin
              state       <= S_FINAL;
              rnd_final_q <= 1'b1;
              rnd_idx_q   <= FINAL_IDX;
            end else begin
              rnd_idx_q <= rnd_idx_q + 4'd1;
            end
          end
        end

        S_FINAL: begin
          rnd_en_q    <= 1'b0;
          rnd_final_q <= 1'b0;
          rnd_idx_q   <= 4'd0;
          busy_q      <= 1'b0;
          if (ctrl.abort) begin
            state <= S_IDLE;
          end else begin
            state       <= S_DONE;
            out_valid_q <= 1'b1;
            rcon_q      <= rcon_next(rcon_q);
          end
        end

        S_DONE: begin
          // The handshake cycle itself still counts as DONE, so a start
          // arriving here is refused above and flagged as overrun.
          if (ctrl.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end

        default: begin
          state       <= S_IDLE;
          ld_q        <= 1'b0;
          rnd_en_q    <= 1'b0;
          rnd_final_q <= 1'b0;
          rnd_idx_q   <= 4'd0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl.ld        = ld_q;
  assign ctrl.rnd_en    = rnd_en_q;
  assign ctrl.rnd_final = rnd_final_q;
  assign ctrl.rnd_idx   = rnd_idx_q;
  assign ctrl.rcon      = rcon_q;
  assign ctrl.busy      = busy_q;
  assign ctrl.out_valid = out_valid_q;
  assign ctrl.overrun   = overrun_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl (NR=10 and NR=14 side by side)

module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic ovr_clr = 1'b0;

  always #5 clk = ~clk;

  aes_round_ctrl_if if10();
  aes_round_ctrl_if if14();

  assign if10.start = start;
  assign if10.abort = abort;
  assign if10.out_ready = out_ready;
  assign if10.ovr_clr = ovr_clr;
  assign if14.start = start;
  assign if14.abort = abort;
  assign if14.out_ready = out_ready;
  assign if14.ovr_clr = ovr_clr;

  aes_round_ctrl #(.NR(10)) u_dut10 (.ACLK(clk), .ARESET(rst), .ctrl(if10));
  aes_round_ctrl #(.NR(14)) u_dut14 (.ACLK(clk), .ARESET(rst), .ctrl(if14));

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // rcon for round r (1-based): x^(r-1) in GF(2^8).
  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 1; i < r; i++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    return v;
  endfunction

  // Behavioural model: per instance, 0=idle, 1=active with phase
  // (0=load, 1..NR=round number), 2=result waiting.
  int   nr_of[2] = '{10, 14};
  int   m_state[2];
  int   m_phase[2];
  logic m_ovr[2];
  logic m_fresh[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_state[k] <= 0;
        m_phase[k] <= 0;
        m_ovr[k]   <= 1'b0;
        m_fresh[k] <= 1'b1;
      end else begin
        if (start && m_state[k] != 0) m_ovr[k] <= 1'b1;
        else if (ovr_clr) m_ovr[k] <= 1'b0;
        case (m_state[k])
          0: if (start) begin
            m_state[k] <= 1;
            m_phase[k] <= 0;
            m_fresh[k] <= 1'b0;
          end
          1: if (abort) m_state[k] <= 0;
             else if (m_phase[k] == nr_of[k]) m_state[k] <= 2;
             else m_phase[k] <= m_phase[k] + 1;
          default: if (out_ready) m_state[k] <= 0;
        endcase
      end
    end
  end

  task automatic compare_one(input int k, input logic ld_a, input logic en_a, input logic fin_a,
                             input logic [3:0] idx_a, input logic [7:0] rcon_a, input logic busy_a,
                             input logic ov_a, input logic ovr_a);
    logic act;
    int   ph;
    act = (m_state[k] == 1);
    ph  = m_phase[k];
    check($sformatf("ld NR%0d", nr_of[k]), ld_a, act && ph == 0);
    check($sformatf("rnd_en NR%0d", nr_of[k]), en_a, act && ph >= 1);
    check($sformatf("rnd_final NR%0d", nr_of[k]), fin_a, act && ph == nr_of[k]);
    check($sformatf("rnd_idx NR%0d", nr_of[k]), idx_a, act ? ph : 0);
    check($sformatf("busy NR%0d", nr_of[k]), busy_a, act);
    check($sformatf("out_valid NR%0d", nr_of[k]), ov_a, m_state[k] == 2);
    check($sformatf("overrun NR%0d", nr_of[k]), ovr_a, m_ovr[k]);
    if (act && ph >= 1) check($sformatf("rcon NR%0d r%0d", nr_of[k], ph), rcon_a, rcon_of(ph));
    else if (m_state[k] == 0 && m_fresh[k]) check($sformatf("rcon reset NR%0d", nr_of[k]), rcon_a, 8'h00);
  endtask

  always @(negedge clk) begin
    compare_one(0, if10.ld, if10.rnd_en, if10.rnd_final, if10.rnd_idx, if10.rcon,
                if10.busy, if10.out_valid, if10.overrun);
    compare_one(1, if14.ld, if14.rnd_en, if14.rnd_final, if14.rnd_idx, if14.rcon,
                if14.busy, if14.out_valid, if14.overrun);
  end

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!if10.busy && !if10.out_valid && !if14.busy && !if14.out_valid) ok = 1'b1;
    end
    check("wait_idle timeout", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  // Full block with out_ready=1; records latencies and rcon per round.
  task automatic run_directed(input logic with_abort);
    int         ld_c[2];
    int         fin_c[2];
    int         ov_c[2];
    int         en_n[2];
    int         ov_n[2];
    logic [7:0] rc10[16];
    logic [7:0] rc14[16];
    logic [7:0] exp_rc[14];
    exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
               8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};
    for (int k = 0; k < 2; k++) begin
      ld_c[k] = -1; fin_c[k] = -1; ov_c[k] = -1; en_n[k] = 0; ov_n[k] = 0;
    end
    for (int r = 0; r < 16; r++) begin rc10[r] = 8'hxx; rc14[r] = 8'hxx; end
    out_ready = 1'b1;
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if10.ld && ld_c[0] < 0) ld_c[0] = c;
      if (if14.ld && ld_c[1] < 0) ld_c[1] = c;
      if (if10.rnd_en) begin en_n[0]++; rc10[if10.rnd_idx] = if10.rcon; end
      if (if14.rnd_en) begin en_n[1]++; rc14[if14.rnd_idx] = if14.rcon; end
      if (if10.rnd_final) fin_c[0] = c;
      if (if14.rnd_final) fin_c[1] = c;
      if (if10.out_valid) begin ov_n[0]++; if (ov_c[0] < 0) ov_c[0] = c; end
      if (if14.out_valid) begin ov_n[1]++; if (ov_c[1] < 0) ov_c[1] = c; end
      @(posedge clk); #1;
    end
    check("lat ld NR10", ld_c[0], 1);
    check("lat final NR10", fin_c[0], 11);
    check("lat out_valid NR10", ov_c[0], 12);
    check("rnd_en count NR10", en_n[0], 10);
    check("out_valid cycles NR10", ov_n[0], 1);
    check("lat ld NR14", ld_c[1], 1);
    check("lat final NR14", fin_c[1], 15);
    check("lat out_valid NR14", ov_c[1], 16);
    check("rnd_en count NR14", en_n[1], 14);
    for (int r = 1; r <= 10; r++) check($sformatf("lit rcon NR10 r%0d", r), rc10[r], exp_rc[r-1]);
    for (int r = 1; r <= 14; r++) check($sformatf("lit rcon NR14 r%0d", r), rc14[r], exp_rc[r-1]);
  endtask

  initial begin
    logic found;
    int   vcount;
    int   cooldown;
    int   ov_seen;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", if10.busy, 1'b0);
    check("reset rcon", if10.rcon, 8'h00);
    check("reset overrun", if14.overrun, 1'b0);
    check("model rcon r10", rcon_of(10), 8'h36);
    check("model rcon r14", rcon_of(14), 8'h4D);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Nominal run with latency and rcon literals
    run_directed(1'b0);
    wait_idle();

    // Result held while out_ready=0; start in DONE sets overrun
    out_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (if10.out_valid) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("wait out_valid", found, 1'b1);
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      if (if10.out_valid) vcount++;
      if (i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("out_valid held", vcount, 5);
    out_ready = 1'b1;
    @(negedge clk);
    check("overrun in DONE", if10.overrun, 1'b1);
    check("valid at handshake", if10.out_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("valid after handshake", if10.out_valid, 1'b0);
    check("busy after handshake", if10.busy, 1'b0);
    wait_idle();

    // ovr_clr alone, then start+ovr_clr while busy
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    @(negedge clk);
    check("ovr_clr clears", if10.overrun, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ovr_clr = 1'b0;
    @(negedge clk);
    check("set beats clear", if10.overrun, 1'b1);
    @(posedge clk); #1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    @(negedge clk);
    check("ovr_clr alone", if10.overrun, 1'b0);
    wait_idle();

    // Abort at round 5, then a clean rerun (with abort+start in IDLE)
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (if10.rnd_en && if10.rnd_idx == 4'd5) found = 1'b1;
    end
    check("wait idx5", found, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort busy", if10.busy, 1'b0);
    check("abort rnd_en", if10.rnd_en, 1'b0);
    check("abort busy NR14", if14.busy, 1'b0);
    ov_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if10.out_valid || if14.out_valid) ov_seen++;
    end
    check("no out_valid after abort", ov_seen, 0);
    @(posedge clk); #1;
    run_directed(1'b1);
    wait_idle();

    // Asynchronous reset mid-cycle at round 7
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (if10.rnd_idx == 4'd7) found = 1'b1;
    end
    check("wait idx7", found, 1'b1);
    check("overrun before reset", if10.overrun, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst ld", if10.ld, 1'b0);
    check("arst rnd_en", if10.rnd_en, 1'b0);
    check("arst rnd_final", if10.rnd_final, 1'b0);
    check("arst rnd_idx", if10.rnd_idx, 4'd0);
    check("arst rcon", if10.rcon, 8'h00);
    check("arst busy", if10.busy, 1'b0);
    check("arst out_valid", if10.out_valid, 1'b0);
    check("arst overrun", if10.overrun, 1'b0);
    check("arst busy NR14", if14.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Randomised traffic against the model
    cooldown = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (rst) begin
        rst = 1'b0;
        cooldown = 3;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
      end
      if (cooldown > 0 || rst) begin
        start = 1'b0;
        if (cooldown > 0) cooldown--;
      end else begin
        start = ($urandom_range(0, 7) == 0);
      end
      abort = ($urandom_range(0, 29) == 0);
      out_ready = $urandom_range(0, 1);
      ovr_clr = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    ovr_clr = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
